// File: rtl/quad_osc_pkg.sv
// quad_osc_pkg: controller state encoding and configuration helpers shared by
// the quadrature oscillator files.
package quad_osc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Largest cosine amplitude (3/8 of full scale) that keeps the recurrence
  // inside WIDTH bits for every legal shift.
  function automatic logic [31:0] amp_max(input int unsigned width);
    return 32'd3 << (width - 32'd3);
  endfunction

  // Amplitude requests are unsigned; anything above the safe limit is clipped.
  function automatic logic [31:0] amp_clip(input logic [31:0] amp,
                                           input logic [31:0] limit);
    if (amp > limit) return limit;
    return amp;
  endfunction

  // Shift 0 would diverge and WIDTH-1 or more would freeze the oscillator.
  function automatic logic [31:0] shift_clamp(input logic [31:0] shift,
                                              input int unsigned width);
    if (shift < 32'd1) return 32'd1;
    if (shift > width - 32'd2) return width - 32'd2;
    return shift;
  endfunction

endpackage

// File: rtl/quad_osc_if.sv
// quad_osc_if: run enable, configuration handshake and oscillator outputs.
// The period counter signal exists only when QUAD_OSC_PERIOD_CNT_EN is defined.
interface quad_osc_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  localparam int SH_W = $clog2(WIDTH);

  logic                    en;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [WIDTH-1:0]        cfg_amp;
  logic [SH_W-1:0]         cfg_shift;
  logic signed [WIDTH-1:0] sine;
  logic signed [WIDTH-1:0] cos;
  logic [OUT_W-1:0]        sine_u;
  logic [OUT_W-1:0]        cos_u;
  logic                    step;
  logic                    wrap;
`ifdef QUAD_OSC_PERIOD_CNT_EN
  logic [CNT_W-1:0]        period_cnt;

  modport master (output en, cfg_valid, cfg_amp, cfg_shift,
                  input  cfg_ready, sine, cos, sine_u, cos_u, step, wrap, period_cnt);
  modport slave  (input  en, cfg_valid, cfg_amp, cfg_shift,
                  output cfg_ready, sine, cos, sine_u, cos_u, step, wrap, period_cnt);
`else
  modport master (output en, cfg_valid, cfg_amp, cfg_shift,
                  input  cfg_ready, sine, cos, sine_u, cos_u, step, wrap);
  modport slave  (input  en, cfg_valid, cfg_amp, cfg_shift,
                  output cfg_ready, sine, cos, sine_u, cos_u, step, wrap);
`endif

endinterface

// File: rtl/quad_osc_step.sv
// quad_osc_step: one iteration of the shifted two-term recurrence. The new
// sine feeds the cosine update, which keeps the orbit closed (no amplitude drift).
module quad_osc_step #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0]         sine,
  input  logic signed [WIDTH-1:0]         cos,
  input  logic        [$clog2(WIDTH)-1:0] shift,
  output logic signed [WIDTH-1:0]         sine_next,
  output logic signed [WIDTH-1:0]         cos_next
);

  assign sine_next = sine + (cos >>> shift);
  assign cos_next  = cos - (sine_next >>> shift);

endmodule

// File: rtl/quad_osc.sv
// quad_osc: quadrature sine/cosine oscillator with a handshake-loaded amplitude
// and frequency shift, registered outputs, step strobe and per-period wrap pulse.
// Optional feature: define QUAD_OSC_PERIOD_CNT_EN to add the period_cnt counter.
module quad_osc
  import quad_osc_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int OUT_W         = 8,
  parameter int AMP_DEFAULT   = 3 * (2 ** (WIDTH - 3)),
  parameter int SHIFT_DEFAULT = 3,
  parameter int CNT_W         = 16
) (
  input logic      clk,
  input logic      reset,
  quad_osc_if.slave bus
);

  localparam int                      SH_W      = $clog2(WIDTH);
  localparam logic [31:0]             AMP_MAX   = amp_max(WIDTH);
  localparam logic signed [WIDTH-1:0] AMP_RST   = WIDTH'(AMP_DEFAULT);
  localparam logic [SH_W-1:0]         SHIFT_RST = SH_W'(SHIFT_DEFAULT);

  if (WIDTH < 6 || OUT_W < 2 || OUT_W > WIDTH || CNT_W < 1) begin : g_param_check
    $error("quad_osc: illegal parameter combination");
  end

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] sine_q, sine_d;
  logic signed [WIDTH-1:0] cos_q, cos_d;
  logic signed [WIDTH-1:0] sine_nxt, cos_nxt;
  logic [SH_W-1:0]         shift_q, shift_d;
  logic                    step_q, step_d;
  logic                    wrap_q, wrap_d;
  logic                    cfg_ready_q, cfg_ready_d;
  logic                    accept;
  logic                    do_step;
  logic                    do_load;

  quad_osc_step #(.WIDTH(WIDTH)) u_step (
    .sine      (sine_q),
    .cos       (cos_q),
    .shift     (shift_q),
    .sine_next (sine_nxt),
    .cos_next  (cos_nxt)
  );

  // Controller: an accepted configuration pre-empts the run enable.
  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    do_load = 1'b0;
    accept  = bus.cfg_valid & cfg_ready_q;
    unique case (state_q)
      IDLE:    if (bus.en) state_d = RUN;
      LOAD:    state_d = bus.en ? RUN : IDLE;
      RUN: begin
        if (bus.en) do_step = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = LOAD;
      do_load = 1'b1;
      do_step = 1'b0;
    end
  end

  // Next oscillator state, strobes and handshake ready.
  always_comb begin
    sine_d      = sine_q;
    cos_d       = cos_q;
    shift_d     = shift_q;
    step_d      = do_step;
    wrap_d      = do_step & sine_q[WIDTH-1] & ~sine_nxt[WIDTH-1];
    cfg_ready_d = (state_d != LOAD);
    if (do_load) begin
      sine_d  = '0;
      cos_d   = WIDTH'(amp_clip(32'(bus.cfg_amp), AMP_MAX));
      shift_d = SH_W'(shift_clamp(32'(bus.cfg_shift), WIDTH));
    end else if (do_step) begin
      sine_d = sine_nxt;
      cos_d  = cos_nxt;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sine_q      <= '0;
      cos_q       <= AMP_RST;
      shift_q     <= SHIFT_RST;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sine_q      <= sine_d;
      cos_q       <= cos_d;
      shift_q     <= shift_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

`ifdef QUAD_OSC_PERIOD_CNT_EN
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;

  // Completed-period counter; a reload restarts the count.
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (do_load)     period_cnt_d = '0;
    else if (wrap_d) period_cnt_d = period_cnt_q + 1'b1;
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (!reset) period_cnt_q <= '0;
    else        period_cnt_q <= period_cnt_d;
  end

  assign bus.period_cnt = period_cnt_q;
`endif

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.sine      = sine_q;
  assign bus.cos       = cos_q;
  assign bus.sine_u    = {~sine_q[WIDTH-1], sine_q[WIDTH-2 -: OUT_W-1]};
  assign bus.cos_u     = {~cos_q[WIDTH-1], cos_q[WIDTH-2 -: OUT_W-1]};
  assign bus.step      = step_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_quad_osc.sv
// tb_quad_osc: directed tests for quad_osc on an 8-bit and a 16-bit instance.
module tb_quad_osc;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  quad_osc_if #(.WIDTH(8),  .OUT_W(8)) bus8 ();
  quad_osc_if #(.WIDTH(16), .OUT_W(8)) bus16 ();

  quad_osc #(.WIDTH(8), .OUT_W(8), .AMP_DEFAULT(120), .SHIFT_DEFAULT(3), .CNT_W(16)) u_osc8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  quad_osc #(.WIDTH(16), .OUT_W(8), .AMP_DEFAULT(24576), .SHIFT_DEFAULT(3), .CNT_W(16)) u_osc16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus8.en = 0;  bus8.cfg_valid = 0;  bus8.cfg_amp = '0;  bus8.cfg_shift = '0;
    bus16.en = 0; bus16.cfg_valid = 0; bus16.cfg_amp = '0; bus16.cfg_shift = '0;
    tick();
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd0) begin err_cnt++; $display("FAIL rst_sine got %0d want 0", bus16.sine); end
    vec_cnt++; if (bus16.cos !== 16'sd24576) begin err_cnt++; $display("FAIL rst_cos got %0d want 24576", bus16.cos); end
    vec_cnt++; if (bus16.step !== 1'b0 || bus16.wrap !== 1'b0) begin err_cnt++; $display("FAIL rst_strobes got step=%b wrap=%b want 0/0", bus16.step, bus16.wrap); end
    vec_cnt++; if (bus16.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready_low got %b want 0", bus16.cfg_ready); end
    vec_cnt++; if (bus16.sine_u !== 8'h80 || bus16.cos_u !== 8'hE0) begin err_cnt++; $display("FAIL rst_offset_bin got %h/%h want 80/e0", bus16.sine_u, bus16.cos_u); end
    vec_cnt++; if (bus8.cos !== 8'sd120 || bus8.sine !== 8'sd0) begin err_cnt++; $display("FAIL rst8 got (%0d,%0d) want (0,120)", bus8.sine, bus8.cos); end
`ifdef QUAD_OSC_PERIOD_CNT_EN
    vec_cnt++; if (bus16.period_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_period_cnt got %0d want 0", bus16.period_cnt); end
`endif
    reset = 1'b1;
    tick();
    vec_cnt++; if (bus16.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready_after got %b want 1", bus16.cfg_ready); end
    vec_cnt++; if (bus16.sine !== 16'sd0 || bus16.step !== 1'b0) begin err_cnt++; $display("FAIL idle_hold got sine=%0d step=%b want 0/0", bus16.sine, bus16.step); end
  endtask

  task automatic test_step8();
    bus8.en = 1;
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd0 || bus8.step !== 1'b0) begin err_cnt++; $display("FAIL step8_first_edge got sine=%0d step=%b want 0/0", bus8.sine, bus8.step); end
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd15 || bus8.cos !== 8'sd119 || bus8.step !== 1'b1) begin err_cnt++; $display("FAIL step8_1 got (%0d,%0d) step=%b want (15,119) 1", bus8.sine, bus8.cos, bus8.step); end
    vec_cnt++; if (bus8.sine_u !== 8'h8F) begin err_cnt++; $display("FAIL step8_sine_u got %h want 8f", bus8.sine_u); end
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd29 || bus8.cos !== 8'sd116 || bus8.step !== 1'b1) begin err_cnt++; $display("FAIL step8_2 got (%0d,%0d) step=%b want (29,116) 1", bus8.sine, bus8.cos, bus8.step); end
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd43 || bus8.cos !== 8'sd111 || bus8.step !== 1'b1) begin err_cnt++; $display("FAIL step8_3 got (%0d,%0d) step=%b want (43,111) 1", bus8.sine, bus8.cos, bus8.step); end
    bus8.en = 0;
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd43 || bus8.cos !== 8'sd111 || bus8.step !== 1'b0) begin err_cnt++; $display("FAIL step8_stop got (%0d,%0d) step=%b want (43,111) 0", bus8.sine, bus8.cos, bus8.step); end
  endtask

  task automatic test_cfg8();
    bus8.cfg_amp = 8'd255; bus8.cfg_shift = 3'd0; bus8.cfg_valid = 1;
    tick();
    bus8.cfg_valid = 0;
    vec_cnt++; if (bus8.sine !== 8'sd0 || bus8.cos !== 8'sd96) begin err_cnt++; $display("FAIL cfg8_amp_clip got (%0d,%0d) want (0,96)", bus8.sine, bus8.cos); end
    vec_cnt++; if (bus8.cfg_ready !== 1'b0 || bus8.step !== 1'b0) begin err_cnt++; $display("FAIL cfg8_load_cycle got ready=%b step=%b want 0/0", bus8.cfg_ready, bus8.step); end
    bus8.en = 1;
    tick();
    vec_cnt++; if (bus8.cfg_ready !== 1'b1 || bus8.step !== 1'b0 || bus8.sine !== 8'sd0) begin err_cnt++; $display("FAIL cfg8_after_load got ready=%b step=%b sine=%0d want 1/0/0", bus8.cfg_ready, bus8.step, bus8.sine); end
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd48 || bus8.cos !== 8'sd72) begin err_cnt++; $display("FAIL cfg8_shift_min_1 got (%0d,%0d) want (48,72)", bus8.sine, bus8.cos); end
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd84 || bus8.cos !== 8'sd30) begin err_cnt++; $display("FAIL cfg8_shift_min_2 got (%0d,%0d) want (84,30)", bus8.sine, bus8.cos); end
    bus8.en = 0;
    tick();
    bus8.cfg_amp = 8'd64; bus8.cfg_shift = 3'd7; bus8.cfg_valid = 1; bus8.en = 1;
    tick();
    bus8.cfg_valid = 0;
    vec_cnt++; if (bus8.sine !== 8'sd0 || bus8.cos !== 8'sd64 || bus8.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL cfg8_accept_over_en got (%0d,%0d) ready=%b want (0,64) 0", bus8.sine, bus8.cos, bus8.cfg_ready); end
    tick();
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd1 || bus8.cos !== 8'sd64) begin err_cnt++; $display("FAIL cfg8_shift_max_1 got (%0d,%0d) want (1,64)", bus8.sine, bus8.cos); end
    tick();
    vec_cnt++; if (bus8.sine !== 8'sd2 || bus8.cos !== 8'sd64) begin err_cnt++; $display("FAIL cfg8_shift_max_2 got (%0d,%0d) want (2,64)", bus8.sine, bus8.cos); end
    bus8.en = 0;
    tick();
  endtask

  task automatic test_wrap_period();
    int steps;
    int last_wrap;
    int wraps;
    int max_abs;
    int v;
    steps = 0; last_wrap = -1; wraps = 0; max_abs = 0;
    bus16.cfg_amp = 16'd24576; bus16.cfg_shift = 4'd4; bus16.cfg_valid = 1; bus16.en = 1;
    tick();
    bus16.cfg_valid = 0;
    for (int i = 0; i < 440; i++) begin
      tick();
      if (bus16.step === 1'b1) begin
        steps++;
        v = bus16.sine;
        if (v < 0) v = -v;
        if (v > max_abs) max_abs = v;
      end
      if (bus16.wrap === 1'b1) begin
        wraps++;
        vec_cnt++; if (bus16.step !== 1'b1 || bus16.sine < 0) begin err_cnt++; $display("FAIL wrap_qual got step=%b sine=%0d want 1 and sine>=0", bus16.step, bus16.sine); end
        if (last_wrap >= 0) begin
          vec_cnt++; if (steps - last_wrap < 100 || steps - last_wrap > 101) begin err_cnt++; $display("FAIL wrap_spacing got %0d want 100..101", steps - last_wrap); end
        end
        last_wrap = steps;
      end
    end
    vec_cnt++; if (wraps < 3 || wraps > 5) begin err_cnt++; $display("FAIL wrap_count got %0d want 3..5", wraps); end
    vec_cnt++; if (max_abs > 25400) begin err_cnt++; $display("FAIL sine_peak got %0d want <=25400", max_abs); end
`ifdef QUAD_OSC_PERIOD_CNT_EN
    vec_cnt++; if (bus16.period_cnt !== 16'(wraps)) begin err_cnt++; $display("FAIL period_cnt got %0d want %0d", bus16.period_cnt, wraps); end
`endif
    bus16.en = 0;
    tick();
  endtask

  task automatic test_load_pending();
    bus16.en = 1;
    tick();
    tick();
    bus16.cfg_amp = 16'd1000; bus16.cfg_shift = 4'd5; bus16.cfg_valid = 1; bus16.en = 0;
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd0 || bus16.cos !== 16'sd1000 || bus16.step !== 1'b0 || bus16.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL run_accept got (%0d,%0d) step=%b ready=%b want (0,1000) 0 0", bus16.sine, bus16.cos, bus16.step, bus16.cfg_ready); end
`ifdef QUAD_OSC_PERIOD_CNT_EN
    vec_cnt++; if (bus16.period_cnt !== 16'd0) begin err_cnt++; $display("FAIL load_clears_cnt got %0d want 0", bus16.period_cnt); end
`endif
    bus16.cfg_amp = 16'd2000; bus16.cfg_shift = 4'd2;
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd0 || bus16.cos !== 16'sd1000 || bus16.step !== 1'b0 || bus16.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL pending_held got (%0d,%0d) step=%b ready=%b want (0,1000) 0 1", bus16.sine, bus16.cos, bus16.step, bus16.cfg_ready); end
    tick();
    bus16.cfg_valid = 0;
    vec_cnt++; if (bus16.cos !== 16'sd2000 || bus16.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL pending_accept got cos=%0d ready=%b want 2000 0", bus16.cos, bus16.cfg_ready); end
    bus16.en = 1;
    tick();
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd500 || bus16.cos !== 16'sd1875 || bus16.step !== 1'b1) begin err_cnt++; $display("FAIL shift2_step got (%0d,%0d) step=%b want (500,1875) 1", bus16.sine, bus16.cos, bus16.step); end
    bus16.en = 0;
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd500 || bus16.step !== 1'b0) begin err_cnt++; $display("FAIL stop_hold got sine=%0d step=%b want 500 0", bus16.sine, bus16.step); end
  endtask

  task automatic test_reset_mid_run();
    bus16.en = 1;
    tick();
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd968 || bus16.cos !== 16'sd1633) begin err_cnt++; $display("FAIL pre_reset_step got (%0d,%0d) want (968,1633)", bus16.sine, bus16.cos); end
    tick();
    reset = 1'b0;
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd0 || bus16.cos !== 16'sd24576 || bus16.step !== 1'b0 || bus16.wrap !== 1'b0 || bus16.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL mid_reset got (%0d,%0d) step=%b wrap=%b ready=%b want (0,24576) 0 0 0", bus16.sine, bus16.cos, bus16.step, bus16.wrap, bus16.cfg_ready); end
    reset = 1'b1;
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd0 || bus16.step !== 1'b0 || bus16.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL resume_wait got sine=%0d step=%b ready=%b want 0 0 1", bus16.sine, bus16.step, bus16.cfg_ready); end
    tick();
    vec_cnt++; if (bus16.sine !== 16'sd3072 || bus16.cos !== 16'sd24192 || bus16.step !== 1'b1) begin err_cnt++; $display("FAIL resume_step got (%0d,%0d) step=%b want (3072,24192) 1", bus16.sine, bus16.cos, bus16.step); end
    vec_cnt++; if (bus8.sine !== 8'sd0 || bus8.cos !== 8'sd120) begin err_cnt++; $display("FAIL reset8_defaults got (%0d,%0d) want (0,120)", bus8.sine, bus8.cos); end
    bus16.en = 0;
    tick();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_step8();
    test_cfg8();
    test_wrap_period();
    test_load_pending();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
